layer_compositor_pipe: RTL
==========================

Name: layer_compositor_pipe

Overview:
- Parametrised, pipelined successor to the combinational video layer priority mux; merges PLANES colour planes from sprite/BG engines into one pixel stream for the VGA output block.
- Adds per-plane enable, programmable transparent key colour and per-plane 50% blend mode.
- Configuration is shadowed and applied only at frame start, so changes never tear mid-frame.
- Carries count_h/count_v alongside the pixel so timing stays aligned.

Parameters:
- PLANES, 4, number of input planes; plane 0 lowest priority, PLANES-1 highest.
- WIDTH, 32, colour word width; multiple of 8, each byte is one channel.
- CW, 32, width of count_h/count_v.
- IW, $clog2(PLANES) (min 1), width of winning-plane index.

Ports:
- clk  in  1  pixel clock.
- reset  in  1  asynchronous, active-high reset.
- valid_in  in  1  pixel qualifier.
- color_in  in  PLANES*WIDTH  plane k at bits [k*WIDTH +: WIDTH].
- count_h_in  in  CW  horizontal position of this pixel.
- count_v_in  in  CW  vertical position of this pixel.
- cfg_enable  in  PLANES  plane enable, live value.
- cfg_blend  in  PLANES  per-plane blend-over-below flag, live value.
- cfg_key  in  WIDTH  transparent key colour, live value.
- valid_out  out  1  output pixel qualifier.
- color_out  out  WIDTH  composited colour.
- plane_out  out  IW  index of highest opaque plane; 0 if none.
- opaque_out  out  1  at least one plane opaque.
- count_h_out  out  CW  count_h_in delayed by LAT.
- count_v_out  out  CW  count_v_in delayed by LAT.

Behaviour:
- Reset: asynchronous, active-high. All outputs and pipeline registers go to 0. Shadow config resets to enable all ones, blend 0, key 0.
- Reset asserted mid-stream: pipeline flushes; valid_out is 0 on the first edge after reset release until new pixels emerge LAT cycles later.
- Shadow config load: on any edge with valid_in=1 and count_h_in=0 and count_v_in=0, the shadow registers take cfg_*. The new values apply from that same pixel onward, because the shadow feeds the input stage in parallel.
- Pipeline: one input register stage, then PLANES stages. Stage k evaluates plane k. LAT = PLANES+1 cycles from a valid_in edge to valid_out.
- No backpressure. One pixel per cycle is accepted, so throughput is 1.
- Bubbles (valid_in=0) propagate as valid_out=0. Data in a bubble is don't-care but must be deterministic (held at 0).
- Plane k is opaque iff shadow enable[k]=1 and color_k != shadow key.
- Stage k update rule, with accumulator {acc, accv, idx} starting at {0, 0, 0}:
  - plane k not opaque: pass the accumulator through unchanged.
  - opaque, blend[k]=0 or accv=0: acc = color_k, accv = 1, idx = k.
  - opaque, blend[k]=1 and accv=1: each byte = (color_k.byte + acc.byte) >> 1 using a 9-bit sum, truncated; accv = 1; idx = k.
- Output: color_out = acc, which is 0 when no plane is opaque. opaque_out = accv. plane_out = idx.
- Key equal to 0 with all planes enabled reproduces the legacy "0 = transparent" priority behaviour exactly.
- Simultaneous frame-start load and reset: reset wins.

Decomposition:
- Package layer_compositor_pkg:
  - reset constants for the shadow registers;
  - blend function (byte-wise average);
  - LAT definition.
- One sub-module, layer_compositor_stage: single-plane evaluate-and-register stage, instantiated PLANES times via generate. It carries valid, count_h/count_v and the remaining colour vector.

Test Plan:
- Legacy priority (PLANES=4, key=0, all enabled, no blend): planes = {0, 0x00FF0000, 0, 0x000000FF}, i.e. plane3 = 0, plane2 = 0x00FF0000, plane1 = 0, plane0 = 0x000000FF -> color_out = 0x00FF0000, plane_out = 2, valid_out exactly 5 cycles after valid_in.
- Key colour: cfg_key = 0x00FF00FF loaded at pixel (0,0); plane3 = 0x00FF00FF, plane1 = 0x00123456 -> color_out = 0x00123456, plane_out = 1.
- Blend: blend[2] = 1; plane2 = 0x00FF8001, plane0 = 0x00010203, others 0 -> color_out = 0x00804102, plane_out = 2. Same setup with plane0 = 0 -> color_out = 0x00FF8001.
- Frame-boundary shadowing: change cfg_enable to 4'b1110 at pixel (5,3) -> no effect until the next pixel with h=0, v=0. From that pixel on, plane0-only pixels give opaque_out = 0, color_out = 0.
- Bubbles and alignment: random valid_in pattern with ramping count_h -> valid_out and count_h_out equal the inputs delayed by exactly 5 cycles; no pixel dropped or duplicated.
- Reset mid-stream: assert reset for 1 cycle during a continuous stream -> all outputs 0 immediately; valid_out returns 5 cycles after the first post-reset valid_in; shadow enable reads back as all ones.

Source files
------------

// File: rtl/layer_compositor_pkg.sv
// Shared constants and helpers for the layer compositor pipeline.
package layer_compositor_pkg;

  // Per-bit reset values of the frame-shadowed configuration.
  localparam logic SHADOW_EN_RST    = 1'b1;
  localparam logic SHADOW_BLEND_RST = 1'b0;
  localparam logic SHADOW_KEY_RST   = 1'b0;

  // Input register stage plus one stage per plane.
  function automatic int unsigned lat(input int unsigned planes);
    return planes + 1;
  endfunction

  // 50% mix of one channel; the 9-bit sum keeps the carry before the shift.
  function automatic logic [7:0] blend_byte(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[8:1];
  endfunction

endpackage

// File: rtl/layer_compositor_stage.sv
// One plane of the compositor: fold plane K into the running accumulator and register.
module layer_compositor_stage
  import layer_compositor_pkg::*;
#(
  parameter int PLANES = 4,
  parameter int WIDTH  = 32,
  parameter int CW     = 32,
  parameter int IW     = 2,
  parameter int K      = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     valid_in,
  input  logic [PLANES*WIDTH-1:0]  color_in,
  input  logic [PLANES-1:0]        plane_opq_in,
  input  logic [PLANES-1:0]        plane_blend_in,
  input  logic [WIDTH-1:0]         acc_in,
  input  logic                     accv_in,
  input  logic [IW-1:0]            idx_in,
  input  logic [CW-1:0]            count_h_in,
  input  logic [CW-1:0]            count_v_in,
  output logic                     valid_out,
  output logic [PLANES*WIDTH-1:0]  color_out,
  output logic [PLANES-1:0]        plane_opq_out,
  output logic [PLANES-1:0]        plane_blend_out,
  output logic [WIDTH-1:0]         acc_out,
  output logic                     accv_out,
  output logic [IW-1:0]            idx_out,
  output logic [CW-1:0]            count_h_out,
  output logic [CW-1:0]            count_v_out
);

  localparam int NB = WIDTH / 8;

  logic [WIDTH-1:0] color_k;
  logic [WIDTH-1:0] mixed;
  logic [WIDTH-1:0] acc_nxt;
  logic             accv_nxt;
  logic [IW-1:0]    idx_nxt;

  assign color_k = color_in[K*WIDTH +: WIDTH];

  for (genvar b = 0; b < NB; b++) begin : g_byte
    assign mixed[b*8 +: 8] = blend_byte(color_k[b*8 +: 8], acc_in[b*8 +: 8]);
  end

  always_comb begin
    acc_nxt  = acc_in;
    accv_nxt = accv_in;
    idx_nxt  = idx_in;
    if (plane_opq_in[K]) begin
      acc_nxt  = (plane_blend_in[K] && accv_in) ? mixed : color_k;
      accv_nxt = 1'b1;
      idx_nxt  = IW'(K);
    end
  end

  // Bubbles are forced to zero so idle data stays deterministic.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_out       <= 1'b0;
      color_out       <= '0;
      plane_opq_out   <= '0;
      plane_blend_out <= '0;
      acc_out         <= '0;
      accv_out        <= 1'b0;
      idx_out         <= '0;
      count_h_out     <= '0;
      count_v_out     <= '0;
    end else if (valid_in) begin
      valid_out       <= 1'b1;
      color_out       <= color_in;
      plane_opq_out   <= plane_opq_in;
      plane_blend_out <= plane_blend_in;
      acc_out         <= acc_nxt;
      accv_out        <= accv_nxt;
      idx_out         <= idx_nxt;
      count_h_out     <= count_h_in;
      count_v_out     <= count_v_in;
    end else begin
      valid_out       <= 1'b0;
      color_out       <= '0;
      plane_opq_out   <= '0;
      plane_blend_out <= '0;
      acc_out         <= '0;
      accv_out        <= 1'b0;
      idx_out         <= '0;
      count_h_out     <= '0;
      count_v_out     <= '0;
    end
  end

endmodule

// File: rtl/layer_compositor_pipe.sv
// Pipelined multi-plane compositor with key colour, per-plane enable/blend and frame-shadowed config.
module layer_compositor_pipe
  import layer_compositor_pkg::*;
#(
  parameter int PLANES = 4,
  parameter int WIDTH  = 32,
  parameter int CW     = 32,
  parameter int IW     = (PLANES > 1) ? $clog2(PLANES) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    valid_in,
  input  logic [PLANES*WIDTH-1:0] color_in,
  input  logic [CW-1:0]           count_h_in,
  input  logic [CW-1:0]           count_v_in,
  input  logic [PLANES-1:0]       cfg_enable,
  input  logic [PLANES-1:0]       cfg_blend,
  input  logic [WIDTH-1:0]        cfg_key,
  output logic                    valid_out,
  output logic [WIDTH-1:0]        color_out,
  output logic [IW-1:0]           plane_out,
  output logic                    opaque_out,
  output logic [CW-1:0]           count_h_out,
  output logic [CW-1:0]           count_v_out
);

  localparam int unsigned LAT  = lat(PLANES);
  localparam int          NSTG = int'(LAT) - 1;

  logic [PLANES-1:0] sh_en, sh_blend;
  logic [WIDTH-1:0]  sh_key;
  logic              frame_start;
  logic [PLANES-1:0] eff_en, eff_blend, opq_now;
  logic [WIDTH-1:0]  eff_key;

  // The frame-start pixel already sees the incoming config, so bypass the shadow.
  assign frame_start = valid_in && (count_h_in == '0) && (count_v_in == '0);
  assign eff_en      = frame_start ? cfg_enable : sh_en;
  assign eff_blend   = frame_start ? cfg_blend  : sh_blend;
  assign eff_key     = frame_start ? cfg_key    : sh_key;

  for (genvar k = 0; k < PLANES; k++) begin : g_opq
    assign opq_now[k] = eff_en[k] && (color_in[k*WIDTH +: WIDTH] != eff_key);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_en    <= {PLANES{SHADOW_EN_RST}};
      sh_blend <= {PLANES{SHADOW_BLEND_RST}};
      sh_key   <= {WIDTH{SHADOW_KEY_RST}};
    end else if (frame_start) begin
      sh_en    <= cfg_enable;
      sh_blend <= cfg_blend;
      sh_key   <= cfg_key;
    end
  end

  // Opacity and blend flags travel with each pixel so a mid-pipe config
  // change cannot affect pixels accepted earlier.
  logic                    in_valid;
  logic [PLANES*WIDTH-1:0] in_color;
  logic [PLANES-1:0]       in_opq, in_blend;
  logic [CW-1:0]           in_h, in_v;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_valid <= 1'b0;
      in_color <= '0;
      in_opq   <= '0;
      in_blend <= '0;
      in_h     <= '0;
      in_v     <= '0;
    end else if (valid_in) begin
      in_valid <= 1'b1;
      in_color <= color_in;
      in_opq   <= opq_now;
      in_blend <= eff_blend;
      in_h     <= count_h_in;
      in_v     <= count_v_in;
    end else begin
      in_valid <= 1'b0;
      in_color <= '0;
      in_opq   <= '0;
      in_blend <= '0;
      in_h     <= '0;
      in_v     <= '0;
    end
  end

  logic                    valid_s [NSTG+1];
  logic [PLANES*WIDTH-1:0] color_s [NSTG+1];
  logic [PLANES-1:0]       opq_s   [NSTG+1];
  logic [PLANES-1:0]       blend_s [NSTG+1];
  logic [WIDTH-1:0]        acc_s   [NSTG+1];
  logic                    accv_s  [NSTG+1];
  logic [IW-1:0]           idx_s   [NSTG+1];
  logic [CW-1:0]           h_s     [NSTG+1];
  logic [CW-1:0]           v_s     [NSTG+1];

  assign valid_s[0] = in_valid;
  assign color_s[0] = in_color;
  assign opq_s[0]   = in_opq;
  assign blend_s[0] = in_blend;
  assign acc_s[0]   = '0;
  assign accv_s[0]  = 1'b0;
  assign idx_s[0]   = '0;
  assign h_s[0]     = in_h;
  assign v_s[0]     = in_v;

  for (genvar k = 0; k < NSTG; k++) begin : g_stage
    layer_compositor_stage #(
      .PLANES(PLANES),
      .WIDTH (WIDTH),
      .CW    (CW),
      .IW    (IW),
      .K     (k)
    ) u_stage (
      .clk            (clk),
      .reset          (reset),
      .valid_in       (valid_s[k]),
      .color_in       (color_s[k]),
      .plane_opq_in   (opq_s[k]),
      .plane_blend_in (blend_s[k]),
      .acc_in         (acc_s[k]),
      .accv_in        (accv_s[k]),
      .idx_in         (idx_s[k]),
      .count_h_in     (h_s[k]),
      .count_v_in     (v_s[k]),
      .valid_out      (valid_s[k+1]),
      .color_out      (color_s[k+1]),
      .plane_opq_out  (opq_s[k+1]),
      .plane_blend_out(blend_s[k+1]),
      .acc_out        (acc_s[k+1]),
      .accv_out       (accv_s[k+1]),
      .idx_out        (idx_s[k+1]),
      .count_h_out    (h_s[k+1]),
      .count_v_out    (v_s[k+1])
    );
  end

  assign valid_out   = valid_s[NSTG];
  assign color_out   = acc_s[NSTG];
  assign plane_out   = idx_s[NSTG];
  assign opaque_out  = accv_s[NSTG];
  assign count_h_out = h_s[NSTG];
  assign count_v_out = v_s[NSTG];

endmodule
